// File: rtl/axi_w_order_m3_pkg.sv
// Shared definitions for the per-slave AXI write-order scheduler.
//   AXI_NUM_MASTER : number of masters sharing the slave port
//   AXI_LEN_W      : AWLEN width
//   GRANT_M0..M2   : one-hot grant codes
//   order_entry_t  : one recorded AW acceptance {grant, len}
//   is_onehot()    : true when exactly one grant bit is set
package axi_w_order_m3_pkg;

    localparam int AXI_NUM_MASTER = 3;
    localparam int AXI_LEN_W      = 8;

    localparam logic [AXI_NUM_MASTER-1:0] GRANT_M0 = 3'b001;
    localparam logic [AXI_NUM_MASTER-1:0] GRANT_M1 = 3'b010;
    localparam logic [AXI_NUM_MASTER-1:0] GRANT_M2 = 3'b100;

    typedef struct packed {
        logic [AXI_NUM_MASTER-1:0] grant;
        logic [AXI_LEN_W-1:0]      len;
    } order_entry_t;

    function automatic logic is_onehot(input logic [AXI_NUM_MASTER-1:0] g);
        return (g != '0) && ((g & (g - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/axi_order_fifo.sv
// Small synchronous FIFO holding the order of accepted AW transactions.
//   clk, rst_n : clock, asynchronous active-low reset (control only)
//   push, din  : write one entry (caller never pushes while full)
//   pop, dout  : head entry is always visible on dout; pop discards it
//                (caller never pops while empty)
//   full, empty, count : occupancy status, count spans 0..DEPTH
module axi_order_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/axi_w_order_m3.sv
// Per-slave write-order scheduler for the 3-master slave-side mux.
// Records {granted master, AWLEN} of every accepted AW and steers W data
// to the slave strictly in AW acceptance order.
//   AXI_CLK, AXI_RSTn : clock, asynchronous active-low reset
//   channel_en        : low freezes all state and suppresses handshakes
//   AWGRANT           : one-hot AW grant from the slave arbiter
//   S_AWVALID/S_AWLEN : muxed AW request; SLV_AWREADY raw slave ready
//   S_AWREADY         : AWREADY gated by order-FIFO full and channel_en
//   S_WVALID/S_WREADY/S_WLAST : W channel handshake observed
//   w_order_grant     : one-hot master allowed on W, 0 when none pending
//   order_cnt         : order FIFO occupancy
//   wlast_err         : one-cycle pulse after a W/AW protocol error
module axi_w_order_m3
    import axi_w_order_m3_pkg::*;
#(
    parameter int NUM_MASTER = AXI_NUM_MASTER,
    parameter int DEPTH      = 4,
    parameter int W_PTR      = 2
) (
    input  logic                  AXI_CLK,
    input  logic                  AXI_RSTn,
    input  logic                  channel_en,
    input  logic [NUM_MASTER-1:0] AWGRANT,
    input  logic                  S_AWVALID,
    input  logic [7:0]            S_AWLEN,
    input  logic                  SLV_AWREADY,
    output logic                  S_AWREADY,
    input  logic                  S_WVALID,
    input  logic                  S_WREADY,
    input  logic                  S_WLAST,
    output logic [NUM_MASTER-1:0] w_order_grant,
    output logic [W_PTR:0]        order_cnt,
    output logic                  wlast_err
);

    order_entry_t push_entry;
    order_entry_t head;
    logic         full;
    logic         empty;
    logic         aw_hs;
    logic         w_hs;
    logic         push;
    logic         pop;
    logic         last_beat;
    logic         err_next;
    logic [7:0]   beat_cnt;

    assign S_AWREADY = SLV_AWREADY & ~full & channel_en;
    assign aw_hs     = S_AWVALID & S_AWREADY;
    assign w_hs      = S_WVALID & S_WREADY & channel_en;

    // A malformed grant would make the W steering ambiguous, so it is
    // dropped rather than recorded.
    assign push = aw_hs & is_onehot(AWGRANT);

    assign last_beat = (beat_cnt == head.len);
    // Either an explicit WLAST or reaching AWLEN closes the burst, so a
    // missing WLAST cannot wedge the order queue.
    assign pop = w_hs & ~empty & (S_WLAST | last_beat);

    assign err_next = (aw_hs & ~is_onehot(AWGRANT))
                    | (w_hs & empty)
                    | (pop & (S_WLAST != last_beat));

    always_comb begin
        push_entry       = '0;
        push_entry.grant = AWGRANT;
        push_entry.len   = S_AWLEN;
    end

    axi_order_fifo #(
        .WIDTH ($bits(order_entry_t)),
        .DEPTH (DEPTH),
        .PTR_W (W_PTR)
    ) u_order_fifo (
        .clk   (AXI_CLK),
        .rst_n (AXI_RSTn),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (order_cnt)
    );

    // 8-bit counter against AWLEN: AWLEN 255 gives 256 beats.
    always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
        if (!AXI_RSTn) begin
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= err_next;
            if (pop)
                beat_cnt <= '0;
            else if (w_hs && !empty)
                beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign w_order_grant = empty ? '0 : head.grant;

endmodule

// File: tb/tb_axi_w_order_m3.sv
module tb_axi_w_order_m3;

    logic       AXI_CLK;
    logic       AXI_RSTn;
    logic       channel_en;
    logic [2:0] AWGRANT;
    logic       S_AWVALID;
    logic [7:0] S_AWLEN;
    logic       SLV_AWREADY;
    logic       S_AWREADY;
    logic       S_WVALID;
    logic       S_WREADY;
    logic       S_WLAST;
    logic [2:0] w_order_grant;
    logic [2:0] order_cnt;
    logic       wlast_err;

    int total;
    int bad;

    axi_w_order_m3 #(.NUM_MASTER(3), .DEPTH(4), .W_PTR(2)) dut (
        .AXI_CLK       (AXI_CLK),
        .AXI_RSTn      (AXI_RSTn),
        .channel_en    (channel_en),
        .AWGRANT       (AWGRANT),
        .S_AWVALID     (S_AWVALID),
        .S_AWLEN       (S_AWLEN),
        .SLV_AWREADY   (SLV_AWREADY),
        .S_AWREADY     (S_AWREADY),
        .S_WVALID      (S_WVALID),
        .S_WREADY      (S_WREADY),
        .S_WLAST       (S_WLAST),
        .w_order_grant (w_order_grant),
        .order_cnt     (order_cnt),
        .wlast_err     (wlast_err)
    );

    initial AXI_CLK = 1'b0;
    always #5 AXI_CLK = ~AXI_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge AXI_CLK);
        #1;
    endtask

    task automatic aw(input logic [2:0] g, input logic [7:0] len);
        S_AWVALID = 1'b1;
        AWGRANT   = g;
        S_AWLEN   = len;
        tick();
        S_AWVALID = 1'b0;
        AWGRANT   = 3'b000;
        S_AWLEN   = 8'd0;
    endtask

    task automatic wbeat(input logic last);
        S_WVALID = 1'b1;
        S_WREADY = 1'b1;
        S_WLAST  = last;
        tick();
        S_WVALID = 1'b0;
        S_WLAST  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        AXI_RSTn    = 1'b0;
        channel_en  = 1'b1;
        AWGRANT     = 3'b000;
        S_AWVALID   = 1'b0;
        S_AWLEN     = 8'd0;
        SLV_AWREADY = 1'b1;
        S_WVALID    = 1'b0;
        S_WREADY    = 1'b0;
        S_WLAST     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", w_order_grant, 3'b000);
        chk("rst_cnt", order_cnt, 3'd0);
        chk("rst_err", wlast_err, 1'b0);
        chk("rst_awready", S_AWREADY, 1'b1);
        AXI_RSTn = 1'b1;
        tick();

        // Single write: M1, AWLEN 3, four beats
        aw(3'b010, 8'd3);
        chk("single_grant", w_order_grant, 3'b010);
        chk("single_cnt", order_cnt, 3'd1);
        wbeat(1'b0);
        wbeat(1'b0);
        wbeat(1'b0);
        chk("single_grant_mid", w_order_grant, 3'b010);
        wbeat(1'b1);
        chk("single_grant_end", w_order_grant, 3'b000);
        chk("single_cnt_end", order_cnt, 3'd0);
        chk("single_err", wlast_err, 1'b0);

        // Ordering: M2 len0, M0 len1, M1 len0
        aw(3'b100, 8'd0);
        aw(3'b001, 8'd1);
        aw(3'b010, 8'd0);
        chk("ord_cnt", order_cnt, 3'd3);
        chk("ord_g0", w_order_grant, 3'b100);
        wbeat(1'b1);
        chk("ord_g1", w_order_grant, 3'b001);
        wbeat(1'b0);
        chk("ord_g2", w_order_grant, 3'b001);
        wbeat(1'b1);
        chk("ord_g3", w_order_grant, 3'b010);
        wbeat(1'b1);
        chk("ord_g4", w_order_grant, 3'b000);
        chk("ord_cnt_end", order_cnt, 3'd0);
        chk("ord_err", wlast_err, 1'b0);

        // Full: four accepted, fifth held off
        for (int i = 0; i < 4; i++) aw(3'b001, 8'd0);
        chk("full_cnt", order_cnt, 3'd4);
        S_AWVALID = 1'b1;
        AWGRANT   = 3'b100;
        #1;
        chk("full_awready", S_AWREADY, 1'b0);
        tick();
        chk("full_cnt_hold", order_cnt, 3'd4);
        S_AWVALID = 1'b0;
        AWGRANT   = 3'b000;
        wbeat(1'b1);
        chk("full_cnt_pop", order_cnt, 3'd3);
        chk("full_awready_back", S_AWREADY, 1'b1);
        wbeat(1'b1);
        wbeat(1'b1);
        wbeat(1'b1);
        chk("full_drain", order_cnt, 3'd0);

        // Early WLAST: AWLEN 2, WLAST on the second beat
        aw(3'b010, 8'd2);
        wbeat(1'b0);
        wbeat(1'b1);
        chk("early_err", wlast_err, 1'b1);
        chk("early_cnt", order_cnt, 3'd0);
        chk("early_grant", w_order_grant, 3'b000);
        tick();
        chk("early_err_clr", wlast_err, 1'b0);

        // Missing WLAST: AWLEN 0, WLAST low
        aw(3'b001, 8'd0);
        wbeat(1'b0);
        chk("miss_err", wlast_err, 1'b1);
        chk("miss_cnt", order_cnt, 3'd0);

        // W beat while empty
        wbeat(1'b1);
        chk("empty_err", wlast_err, 1'b1);
        chk("empty_cnt", order_cnt, 3'd0);
        tick();
        chk("empty_err_clr", wlast_err, 1'b0);

        // Non-one-hot grant is dropped with an error
        aw(3'b011, 8'd0);
        chk("bad_grant_err", wlast_err, 1'b1);
        chk("bad_grant_cnt", order_cnt, 3'd0);
        tick();

        // Simultaneous push and pop at occupancy 1
        aw(3'b100, 8'd0);
        chk("conc_pre_cnt", order_cnt, 3'd1);
        S_AWVALID = 1'b1;
        AWGRANT   = 3'b010;
        S_AWLEN   = 8'd1;
        S_WVALID  = 1'b1;
        S_WREADY  = 1'b1;
        S_WLAST   = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        AWGRANT   = 3'b000;
        S_AWLEN   = 8'd0;
        S_WVALID  = 1'b0;
        S_WLAST   = 1'b0;
        chk("conc_cnt", order_cnt, 3'd1);
        chk("conc_grant", w_order_grant, 3'b010);
        chk("conc_err", wlast_err, 1'b0);
        wbeat(1'b0);
        wbeat(1'b1);
        chk("conc_cnt_end", order_cnt, 3'd0);
        chk("conc_err_end", wlast_err, 1'b0);

        // channel_en low freezes state
        aw(3'b001, 8'd1);
        channel_en = 1'b0;
        S_AWVALID  = 1'b1;
        AWGRANT    = 3'b100;
        S_WVALID   = 1'b1;
        S_WREADY   = 1'b1;
        S_WLAST    = 1'b0;
        #1;
        chk("dis_awready", S_AWREADY, 1'b0);
        tick();
        tick();
        chk("dis_cnt", order_cnt, 3'd1);
        chk("dis_grant", w_order_grant, 3'b001);
        chk("dis_err", wlast_err, 1'b0);
        S_AWVALID  = 1'b0;
        AWGRANT    = 3'b000;
        S_WVALID   = 1'b0;
        channel_en = 1'b1;
        wbeat(1'b0);
        wbeat(1'b1);
        chk("reen_cnt", order_cnt, 3'd0);
        chk("reen_err", wlast_err, 1'b0);

        // AWLEN 255 gives 256 beats
        aw(3'b001, 8'd255);
        for (int i = 0; i < 255; i++) wbeat(1'b0);
        chk("len255_grant", w_order_grant, 3'b001);
        chk("len255_cnt", order_cnt, 3'd1);
        wbeat(1'b1);
        chk("len255_cnt_end", order_cnt, 3'd0);
        chk("len255_err", wlast_err, 1'b0);

        // Asynchronous reset mid-burst
        aw(3'b010, 8'd3);
        aw(3'b100, 8'd0);
        wbeat(1'b0);
        #2;
        AXI_RSTn = 1'b0;
        #1;
        chk("arst_grant", w_order_grant, 3'b000);
        chk("arst_cnt", order_cnt, 3'd0);
        chk("arst_err", wlast_err, 1'b0);
        tick();
        AXI_RSTn = 1'b1;
        tick();
        aw(3'b100, 8'd0);
        chk("post_rst_grant", w_order_grant, 3'b100);
        wbeat(1'b1);
        chk("post_rst_cnt", order_cnt, 3'd0);
        chk("post_rst_err", wlast_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
